// File: rtl/ex_result_buffer_if.sv
// EX->MEM result buffer bus: EX push side, MEM pop side, flush and hold.
// Handshake: a transfer occurs on a rising edge where valid and ready are both 1;
// valid never depends on ready, and in_ready never depends on out_ready.
interface ex_result_buffer_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_pc;
    logic [WIDTH-1:0] in_result;
    logic             in_ov;
    logic             in_sys;
    logic             in_br;
    logic             in_wen;
    logic [4:0]       in_dst;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_pc;
    logic [WIDTH-1:0] out_result;
    logic             out_br;
    logic             out_wen;
    logic [4:0]       out_dst;
    logic             out_exc;
    logic [4:0]       out_exccode;
    logic             hold;

    // The buffer itself.
    modport slave (
        input  flush, in_valid, in_pc, in_result, in_ov, in_sys, in_br, in_wen, in_dst,
        input  out_ready,
        output in_ready, out_valid, out_pc, out_result, out_br, out_wen, out_dst,
        output out_exc, out_exccode, hold
    );

    // The surrounding pipeline (EX producer, MEM consumer, CP0 flush).
    modport master (
        output flush, in_valid, in_pc, in_result, in_ov, in_sys, in_br, in_wen, in_dst,
        output out_ready,
        input  in_ready, out_valid, out_pc, out_result, out_br, out_wen, out_dst,
        input  out_exc, out_exccode, hold
    );
endinterface

// File: rtl/ex_result_buffer.sv
// Registered EX->MEM boundary: captures ALU result and flags, resolves the
// exception code at push, and queues entries in a small FIFO so MEM stalls
// never reach EX combinationally. Outputs come only from registered state.
module ex_result_buffer #(
    parameter int WIDTH   = 32,
    parameter int ENTRIES = 2
) (
    input logic              clk,
    input logic              reset,
    ex_result_buffer_if.slave bus
);
    localparam int PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int CNT_W = $clog2(ENTRIES + 1);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_hold;

    logic [WIDTH-1:0] r_pc     [ENTRIES];
    logic [WIDTH-1:0] r_result [ENTRIES];
    logic             r_br     [ENTRIES];
    logic             r_wen    [ENTRIES];
    logic [4:0]       r_dst    [ENTRIES];
    logic             r_exc    [ENTRIES];
    logic [4:0]       r_code   [ENTRIES];

    logic             w_ready;
    logic             w_valid;
    logic             w_push;
    logic             w_pop;
    logic             w_exc;
    logic [4:0]       w_code;

    // Accept only while there is room and no exception is waiting for flush.
    assign w_ready = (r_count < CNT_W'(ENTRIES)) & ~r_hold;
    assign w_valid = (r_count != '0);
    assign w_push  = bus.in_valid & w_ready;
    assign w_pop   = w_valid & bus.out_ready;

    // Syscall outranks overflow when both are flagged.
    assign w_exc  = bus.in_sys | bus.in_ov;
    assign w_code = bus.in_sys ? 5'h08 : (bus.in_ov ? 5'h0C : 5'h00);

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = w_valid;
    assign bus.hold      = r_hold;

    // Pointer, occupancy and exception-hold bookkeeping; flush acts like a soft reset.
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_hold   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_push && w_exc) begin
                r_hold <= 1'b1;
            end
        end
    end

    // Entry storage; contents are don't-care until counted, so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_push && !bus.flush && !reset) begin
            r_pc[r_wr_ptr]     <= bus.in_pc;
            r_result[r_wr_ptr] <= bus.in_result;
            r_br[r_wr_ptr]     <= bus.in_br;
            r_wen[r_wr_ptr]    <= bus.in_wen & ~w_exc;
            r_dst[r_wr_ptr]    <= bus.in_dst;
            r_exc[r_wr_ptr]    <= w_exc;
            r_code[r_wr_ptr]   <= w_code;
        end
    end

    // Head presentation; zeros while empty so stale storage never leaks out.
    always_comb begin
        bus.out_pc      = '0;
        bus.out_result  = '0;
        bus.out_br      = 1'b0;
        bus.out_wen     = 1'b0;
        bus.out_dst     = 5'd0;
        bus.out_exc     = 1'b0;
        bus.out_exccode = 5'd0;
        if (w_valid) begin
            bus.out_pc      = r_pc[r_rd_ptr];
            bus.out_result  = r_result[r_rd_ptr];
            bus.out_br      = r_br[r_rd_ptr];
            bus.out_wen     = r_wen[r_rd_ptr];
            bus.out_dst     = r_dst[r_rd_ptr];
            bus.out_exc     = r_exc[r_rd_ptr];
            bus.out_exccode = r_code[r_rd_ptr];
        end
    end
endmodule
